// File: rtl/sdram_pkg.sv
// Shared types and constants for the split-DQ SDR SDRAM controller.
package sdram_pkg;

  // Controller states. S_WAIT is a generic delay state that counts down
  // wait_cnt and then jumps to the state held in ret_state.
  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_REF1,
    S_INIT_REF2,
    S_INIT_MODE,
    S_IDLE,
    S_REFRESH,
    S_WR_ACT,
    S_WR_CMD,
    S_RD_ACT,
    S_RD_CMD,
    S_RD_DATA,
    S_WAIT
  } state_t;

  // Commands as {CS_N, RAS_N, CAS_N, WE_N}.
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;

  // Burst length 1, sequential, CAS latency 2, burst write.
  localparam logic [12:0] MODE_REG = 13'h020;

  // Word address = {bank, row, column}.
  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 7;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  // Column address with A10 set so the access auto-precharges.
  function automatic logic [12:0] col_ap(input logic [COL_W-1:0] col);
    return {2'b00, 1'b1, 3'b000, col};
  endfunction

endpackage

// File: rtl/sdram_ctrl_split_dq.sv
// Single-port SDR SDRAM controller: init, periodic refresh, and single-word
// write/read accesses with auto-precharge. Data bus split into dq_read/dq_write.
// Request handshake: iwrite_req/iread_req are levels held by the requester;
// the controller accepts in IDLE and answers with a one-cycle ack pulse
// (owrite_ack with the WRITE command, oread_ack with valid oread_data).
module sdram_ctrl_split_dq
  import sdram_pkg::*;
#(
  parameter int INIT_WAIT      = 50,
  parameter int T_RP           = 2,
  parameter int T_RFC          = 7,
  parameter int T_RCD          = 2,
  parameter int T_WR           = 2,
  parameter int CAS_LATENCY    = 2,
  parameter int REFRESH_PERIOD = 390
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iwrite_req,
  input  logic [21:0] iwrite_address,
  input  logic [15:0] iwrite_data,
  output logic        owrite_ack,
  input  logic        iread_req,
  input  logic [21:0] iread_address,
  output logic [15:0] oread_data,
  output logic        oread_ack,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CAS_N,
  output logic        DRAM_CKE,
  output logic        DRAM_CLK,
  output logic        DRAM_CS_N,
  input  logic [15:0] dq_read,
  output logic [15:0] dq_write,
  output logic        DRAM_LDQM,
  output logic        DRAM_RAS_N,
  output logic        DRAM_UDQM,
  output logic        DRAM_WE_N
);

  state_t             state, state_d, ret_state, ret_d;
  logic [CNT_W-1:0]   wait_cnt, cnt_d;
  logic [CNT_W-1:0]   refresh_cnt;
  logic               refresh_due, init_done;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_data;
  logic               accept_wr, accept_rd;

  logic [3:0]         cmd_q, cmd_d;
  logic [12:0]        addr_q, addr_d;
  logic [1:0]         ba_q, ba_d;
  logic [15:0]        dq_write_q, dq_write_d, rdata_q, rdata_d;
  logic               wack_q, wack_d, rack_q, rack_d, dqm_q, cke_q;

  // State, wait counter and return-state registers.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state     <= S_INIT_WAIT;
      ret_state <= S_INIT_WAIT;
      wait_cnt  <= CNT_W'(INIT_WAIT - 1);
    end else begin
      state     <= state_d;
      ret_state <= ret_d;
      wait_cnt  <= cnt_d;
    end
  end

  // Next-state logic and next values for the registered pins.
  always_comb begin
    state_d    = state;
    ret_d      = ret_state;
    cnt_d      = wait_cnt;
    cmd_d      = CMD_NOP;
    addr_d     = '0;
    ba_d       = '0;
    dq_write_d = '0;
    wack_d     = 1'b0;
    rack_d     = 1'b0;
    rdata_d    = rdata_q;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    case (state)
      S_INIT_WAIT: begin
        if (wait_cnt == '0) state_d = S_INIT_PRE;
        else                cnt_d   = wait_cnt - 1'b1;
      end
      S_INIT_PRE: begin
        cmd_d   = CMD_PRECHARGE;
        addr_d  = 13'h400;
        cnt_d   = CNT_W'(T_RP - 1);
        ret_d   = S_INIT_REF1;
        state_d = S_WAIT;
      end
      S_INIT_REF1: begin
        cmd_d   = CMD_REFRESH;
        cnt_d   = CNT_W'(T_RFC - 1);
        ret_d   = S_INIT_REF2;
        state_d = S_WAIT;
      end
      S_INIT_REF2: begin
        cmd_d   = CMD_REFRESH;
        cnt_d   = CNT_W'(T_RFC - 1);
        ret_d   = S_INIT_MODE;
        state_d = S_WAIT;
      end
      S_INIT_MODE: begin
        cmd_d   = CMD_LOAD_MODE;
        addr_d  = MODE_REG;
        cnt_d   = CNT_W'(1);
        ret_d   = S_IDLE;
        state_d = S_WAIT;
      end
      S_IDLE: begin
        if (refresh_due) begin
          state_d = S_REFRESH;
        end else if (iwrite_req) begin
          accept_wr = 1'b1;
          state_d   = S_WR_ACT;
        end else if (iread_req) begin
          accept_rd = 1'b1;
          state_d   = S_RD_ACT;
        end
      end
      S_REFRESH: begin
        cmd_d   = CMD_REFRESH;
        cnt_d   = CNT_W'(T_RFC - 1);
        ret_d   = S_IDLE;
        state_d = S_WAIT;
      end
      S_WR_ACT, S_RD_ACT: begin
        cmd_d   = CMD_ACTIVE;
        ba_d    = lat_addr[21:20];
        addr_d  = lat_addr[19:7];
        cnt_d   = CNT_W'(T_RCD - 1);
        ret_d   = (state == S_WR_ACT) ? S_WR_CMD : S_RD_CMD;
        state_d = S_WAIT;
      end
      S_WR_CMD: begin
        cmd_d      = CMD_WRITE;
        ba_d       = lat_addr[21:20];
        addr_d     = col_ap(lat_addr[6:0]);
        dq_write_d = lat_data;
        wack_d     = 1'b1;
        cnt_d      = CNT_W'(T_WR + T_RP - 1);
        ret_d      = S_IDLE;
        state_d    = S_WAIT;
      end
      S_RD_CMD: begin
        cmd_d   = CMD_READ;
        ba_d    = lat_addr[21:20];
        addr_d  = col_ap(lat_addr[6:0]);
        cnt_d   = CNT_W'(CAS_LATENCY - 1);
        ret_d   = S_RD_DATA;
        state_d = S_WAIT;
      end
      S_RD_DATA: begin
        rdata_d = dq_read;
        rack_d  = 1'b1;
        cnt_d   = CNT_W'(T_RP - 1);
        ret_d   = S_IDLE;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt <= CNT_W'(1)) state_d = ret_state;
        else                       cnt_d   = wait_cnt - 1'b1;
      end
      default: state_d = S_INIT_WAIT;
    endcase
  end

  // Latch the accepted request so later input changes cannot disturb it.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept_wr) begin
      lat_addr <= iwrite_address;
      lat_data <= iwrite_data;
    end else if (accept_rd) begin
      lat_addr <= iread_address;
    end
  end

  // Refresh timer: free-runs from the first IDLE cycle; a new due wins over the clear.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      init_done   <= 1'b0;
      refresh_cnt <= '0;
      refresh_due <= 1'b0;
    end else begin
      if (state == S_IDLE) init_done <= 1'b1;
      if (state == S_REFRESH) refresh_due <= 1'b0;
      if (init_done || state == S_IDLE) begin
        if (refresh_cnt == CNT_W'(REFRESH_PERIOD - 1)) begin
          refresh_cnt <= '0;
          refresh_due <= 1'b1;
        end else begin
          refresh_cnt <= refresh_cnt + 1'b1;
        end
      end
    end
  end

  // Registered pins and user-side outputs.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      cmd_q      <= 4'b1111;
      addr_q     <= '0;
      ba_q       <= '0;
      dq_write_q <= '0;
      rdata_q    <= '0;
      wack_q     <= 1'b0;
      rack_q     <= 1'b0;
      dqm_q      <= 1'b1;
      cke_q      <= 1'b1;
    end else begin
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      ba_q       <= ba_d;
      dq_write_q <= dq_write_d;
      rdata_q    <= rdata_d;
      wack_q     <= wack_d;
      rack_q     <= rack_d;
      if (state == S_IDLE) dqm_q <= 1'b0;
      cke_q      <= 1'b1;
    end
  end

  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd_q;
  assign DRAM_ADDR  = addr_q;
  assign DRAM_BA    = ba_q;
  assign DRAM_LDQM  = dqm_q;
  assign DRAM_UDQM  = dqm_q;
  assign DRAM_CKE   = cke_q;
  assign DRAM_CLK   = ~iclk;
  assign dq_write   = dq_write_q;
  assign oread_data = rdata_q;
  assign owrite_ack = wack_q;
  assign oread_ack  = rack_q;

endmodule

// File: tb/tb_sdram_ctrl_split_dq.sv
// Testbench for sdram_ctrl_split_dq with a behavioural SDRAM model on the pins.
module tb_sdram_ctrl_split_dq;
  import sdram_pkg::*;

  localparam int INIT_WAIT = 50;
  localparam int T_RP      = 2;
  localparam int T_RFC     = 7;
  localparam int T_RCD     = 2;
  localparam int T_WR      = 2;
  localparam int CL        = 2;
  localparam int REF_P     = 390;

  logic        iclk = 1'b0;
  logic        ireset = 1'b1;
  logic        iwrite_req = 1'b0, iread_req = 1'b0;
  logic [21:0] iwrite_address = '0, iread_address = '0;
  logic [15:0] iwrite_data = '0;
  logic        owrite_ack, oread_ack;
  logic [15:0] oread_data;
  logic [12:0] DRAM_ADDR;
  logic [1:0]  DRAM_BA;
  logic        DRAM_CAS_N, DRAM_CKE, DRAM_CLK, DRAM_CS_N, DRAM_LDQM;
  logic        DRAM_RAS_N, DRAM_UDQM, DRAM_WE_N;
  logic [15:0] dq_read = 16'hDEAD;
  logic [15:0] dq_write;

  sdram_ctrl_split_dq #(
    .INIT_WAIT(INIT_WAIT), .T_RP(T_RP), .T_RFC(T_RFC), .T_RCD(T_RCD),
    .T_WR(T_WR), .CAS_LATENCY(CL), .REFRESH_PERIOD(REF_P)
  ) dut (
    .iclk(iclk), .ireset(ireset),
    .iwrite_req(iwrite_req), .iwrite_address(iwrite_address),
    .iwrite_data(iwrite_data), .owrite_ack(owrite_ack),
    .iread_req(iread_req), .iread_address(iread_address),
    .oread_data(oread_data), .oread_ack(oread_ack),
    .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA), .DRAM_CAS_N(DRAM_CAS_N),
    .DRAM_CKE(DRAM_CKE), .DRAM_CLK(DRAM_CLK), .DRAM_CS_N(DRAM_CS_N),
    .dq_read(dq_read), .dq_write(dq_write), .DRAM_LDQM(DRAM_LDQM),
    .DRAM_RAS_N(DRAM_RAS_N), .DRAM_UDQM(DRAM_UDQM), .DRAM_WE_N(DRAM_WE_N)
  );

  // Clock and cycle counter.
  always #5 iclk = ~iclk;
  int cyc = 0;
  always @(posedge iclk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Pin monitor and SDRAM model, sampled on DRAM_CLK rising (iclk falling).
  typedef struct {int cyc; logic [3:0] cmd; logic [1:0] ba; logic [12:0] addr;} ev_t;
  ev_t         log_q[$];
  int          ref_q[$];
  logic [15:0] mem [int];
  logic [12:0] open_row [4];
  int          last_act_cyc = 0, last_wr_cyc = 0, last_rd_cyc = 0;
  int          wack_cyc = 0, rack_cyc = 0, wack_cnt = 0, rack_cnt = 0;
  logic [1:0]  last_act_ba, last_wr_ba, last_rd_ba;
  logic [12:0] last_act_addr, last_wr_addr, last_rd_addr;
  logic [15:0] last_wr_dq, rd_data;
  int          rd_cnt = 0;
  bit          rd_drive = 0;

  always @(negedge iclk) begin : mon
    logic [3:0] c;
    ev_t e;
    int key;
    c = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin dq_read = rd_data; rd_drive = 1; end
    end else if (rd_drive) begin
      dq_read = 16'hDEAD; rd_drive = 0;
    end
    if (DRAM_CS_N == 1'b0 && c != CMD_NOP) begin
      e.cyc = cyc; e.cmd = c; e.ba = DRAM_BA; e.addr = DRAM_ADDR;
      log_q.push_back(e);
      case (c)
        CMD_ACTIVE: begin
          open_row[DRAM_BA] = DRAM_ADDR;
          last_act_cyc = cyc; last_act_ba = DRAM_BA; last_act_addr = DRAM_ADDR;
        end
        CMD_WRITE: begin
          key = int'({DRAM_BA, open_row[DRAM_BA], DRAM_ADDR[6:0]});
          mem[key] = dq_write;
          last_wr_cyc = cyc; last_wr_ba = DRAM_BA; last_wr_addr = DRAM_ADDR; last_wr_dq = dq_write;
        end
        CMD_READ: begin
          key = int'({DRAM_BA, open_row[DRAM_BA], DRAM_ADDR[6:0]});
          rd_data = mem.exists(key) ? mem[key] : 16'hBEEF;
          rd_cnt = CL - 1;
          last_rd_cyc = cyc; last_rd_ba = DRAM_BA; last_rd_addr = DRAM_ADDR;
        end
        CMD_REFRESH: ref_q.push_back(cyc);
        default: ;
      endcase
    end
    if (owrite_ack) begin wack_cyc = cyc; wack_cnt = wack_cnt + 1; end
    if (oread_ack)  begin rack_cyc = cyc; rack_cnt = rack_cnt + 1; end
  end

  // Scoreboard counters and compare helper.
  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: hold the request level until the ack pulse is seen.
  task automatic do_write(input logic [21:0] a, input logic [15:0] d, output bit ok);
    ok = 0;
    iwrite_address = a; iwrite_data = d; iwrite_req = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge iclk);
      if (owrite_ack) begin ok = 1; break; end
    end
    iwrite_req = 1'b0;
    #1;
  endtask

  task automatic do_read(input logic [21:0] a, output bit ok, output logic [15:0] d);
    ok = 0; d = '0;
    iread_address = a; iread_req = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge iclk);
      if (oread_ack) begin ok = 1; d = oread_data; break; end
    end
    iread_req = 1'b0;
    #1;
  endtask

  task automatic check_init(input int rel);
    check("init_cmd_count", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      check("init_order", {log_q[0].cmd, log_q[1].cmd, log_q[2].cmd, log_q[3].cmd},
            {CMD_PRECHARGE, CMD_REFRESH, CMD_REFRESH, CMD_LOAD_MODE});
      check("init_pre_a10", log_q[0].addr[10], 1'b1);
      check("init_mode_addr", log_q[3].addr, 13'h020);
      check("init_wait_gap", (log_q[0].cyc - rel) >= INIT_WAIT, 1);
      check("init_trp", log_q[1].cyc - log_q[0].cyc, T_RP);
      check("init_trfc1", log_q[2].cyc - log_q[1].cyc, T_RFC);
      check("init_trfc2", log_q[3].cyc - log_q[2].cyc, T_RFC);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [6:0]  col;
  } vec_t;
  vec_t vecs[6];

  initial begin
    bit          ok;
    logic [15:0] rd;
    logic [15:0] exp_hold;
    int          rel, rc0, wc0, prev, d;

    vecs[0] = '{1'b1, 22'h000000, 16'd19,    2'd0, 13'h0000, 7'h00};
    vecs[1] = '{1'b0, 22'h000000, 16'd19,    2'd0, 13'h0000, 7'h00};
    vecs[2] = '{1'b1, 22'h3FFFFF, 16'hABCD,  2'd3, 13'h1FFF, 7'h7F};
    vecs[3] = '{1'b0, 22'h3FFFFF, 16'hABCD,  2'd3, 13'h1FFF, 7'h7F};
    vecs[4] = '{1'b1, 22'h1234AB, 16'h5A3C,  2'd1, 13'h0469, 7'h2B};
    vecs[5] = '{1'b0, 22'h1234AB, 16'h5A3C,  2'd1, 13'h0469, 7'h2B};
    exp_hold = 16'h0000;

    // One-cycle reset, then reset values.
    ireset = 1'b1;
    @(posedge iclk);
    @(negedge iclk);
    check("rst_cmd_pins", {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}, 4'hF);
    check("rst_cke", DRAM_CKE, 1'b1);
    check("rst_ba_addr", {DRAM_BA, DRAM_ADDR}, 15'h0);
    check("rst_dqm", {DRAM_LDQM, DRAM_UDQM}, 2'b11);
    check("rst_dq_write", dq_write, 16'h0);
    check("rst_read_data", oread_data, 16'h0);
    check("rst_acks", {owrite_ack, oread_ack}, 2'b00);
    ireset = 1'b0;
    rel = cyc;
    log_q.delete();
    repeat (100) @(negedge iclk);
    #1;
    check_init(rel);
    check("dqm_after_init", {DRAM_LDQM, DRAM_UDQM}, 2'b00);

    // Table-driven single accesses.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, ok);
        check("wr_ack_seen", ok, 1);
        check("wr_act_ba", last_act_ba, vecs[i].ba);
        check("wr_act_row", last_act_addr, vecs[i].row);
        check("wr_trcd", last_wr_cyc - last_act_cyc, T_RCD);
        check("wr_ba", last_wr_ba, vecs[i].ba);
        check("wr_col", last_wr_addr, 13'h400 | {6'h0, vecs[i].col});
        check("wr_dq", last_wr_dq, vecs[i].data);
        check("wr_ack_with_cmd", wack_cyc - last_wr_cyc, 0);
        @(negedge iclk);
        check("wr_ack_pulse", owrite_ack, 1'b0);
        check("rdata_hold", oread_data, exp_hold);
      end else begin
        do_read(vecs[i].addr, ok, rd);
        check("rd_ack_seen", ok, 1);
        check("rd_data", rd, vecs[i].data);
        check("rd_act_row", last_act_addr, vecs[i].row);
        check("rd_ba", last_rd_ba, vecs[i].ba);
        check("rd_col", last_rd_addr, 13'h400 | {6'h0, vecs[i].col});
        check("rd_cas_latency", rack_cyc - last_rd_cyc, CL);
        exp_hold = vecs[i].data;
        @(negedge iclk);
        check("rd_ack_pulse", oread_ack, 1'b0);
      end
      repeat (3) @(negedge iclk);
    end

    // Both requests held: write wins every time; refresh still gets through.
    ref_q.delete();
    wc0 = wack_cnt; rc0 = rack_cnt;
    iwrite_address = 22'h000100; iwrite_data = 16'h7777;
    iread_address = 22'h1234AB;
    iwrite_req = 1'b1; iread_req = 1'b1;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge iclk);
      if (owrite_ack || oread_ack) begin ok = 1; break; end
    end
    check("prio_ack_seen", ok, 1);
    check("prio_write_first", {owrite_ack, oread_ack}, 2'b10);
    repeat (1000) @(negedge iclk);
    #1;
    check("prio_read_waits", rack_cnt - rc0, 0);
    check("write_reacked", (wack_cnt - wc0) > 20, 1);
    check("refresh_under_traffic", ref_q.size() >= 2, 1);
    for (int k = 1; k < ref_q.size(); k++) begin
      d = ref_q[k] - ref_q[k-1];
      check("refresh_interval", (d >= REF_P - 8 && d <= REF_P + 8) ? REF_P : d, REF_P);
    end
    iwrite_req = 1'b0;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge iclk);
      if (oread_ack) begin ok = 1; rd = oread_data; break; end
    end
    iread_req = 1'b0;
    check("read_after_write_drop", ok, 1);
    check("read_after_write_data", rd, 16'h5A3C);

    // Reset in the middle of a read: no ack, re-init, then a good read.
    repeat (5) @(negedge iclk);
    rc0 = rack_cnt;
    prev = last_rd_cyc;
    iread_address = 22'h3FFFFF; iread_req = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge iclk);
      #1;
      if (last_rd_cyc != prev) begin ok = 1; break; end
    end
    check("midread_cmd_seen", ok, 1);
    ireset = 1'b1; iread_req = 1'b0;
    @(posedge iclk);
    @(negedge iclk);
    ireset = 1'b0;
    rel = cyc;
    log_q.delete();
    repeat (100) @(negedge iclk);
    #1;
    check("midread_no_ack", rack_cnt - rc0, 0);
    check("midread_rdata_reset", oread_data, 16'h0);
    check_init(rel);
    do_read(22'h3FFFFF, ok, rd);
    check("post_reset_rd_ack", ok, 1);
    check("post_reset_rd_data", rd, 16'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_ctrl_split_dq.md
Name: sdram_ctrl_split_dq

Overview:
- Single-port SDRAM controller for a 16-bit SDR SDRAM, for example DE-series boards.
- Serves independent write and read request channels on a 22-bit word address.
- Runs power-up initialisation, periodic auto-refresh and single-word accesses with auto-precharge.
- The data bus is split into dq_read (input) and dq_write (output). A top-level wrapper builds the tristate DRAM_DQ and drives dq_write only while the WRITE command is on the pins.

Parameters:
- INIT_WAIT, 50: cycles of NOP after reset before the init PRECHARGE. Hardware builds override this to at least 100 µs worth of cycles.
- T_RP, 2: PRECHARGE to next command, in cycles.
- T_RFC, 7: REFRESH to next command, in cycles.
- T_RCD, 2: ACTIVE to READ/WRITE, in cycles.
- T_WR, 2: write recovery before auto-precharge completes, in cycles.
- CAS_LATENCY, 2: must match the mode register value.
- REFRESH_PERIOD, 390: cycles between auto-refreshes.

Ports:
- iclk, in, 1: system clock.
- ireset, in, 1: synchronous, active-high reset.
- iwrite_req, in, 1: level write request, held until owrite_ack.
- iwrite_address, in, 22: write word address.
- iwrite_data, in, 16: write data.
- owrite_ack, out, 1: one-cycle pulse when the WRITE command is issued.
- iread_req, in, 1: level read request, held until oread_ack.
- iread_address, in, 22: read word address.
- oread_data, out, 16: last read word.
- oread_ack, out, 1: one-cycle pulse when oread_data is valid.
- DRAM_ADDR, out, 13: row/column/mode address.
- DRAM_BA, out, 2: bank.
- DRAM_CAS_N, out, 1: command pin.
- DRAM_CKE, out, 1: clock enable.
- DRAM_CLK, out, 1: SDRAM clock.
- DRAM_CS_N, out, 1: command pin.
- dq_read, in, 16: data from the SDRAM.
- dq_write, out, 16: data to the SDRAM.
- DRAM_LDQM, out, 1: byte mask.
- DRAM_RAS_N, out, 1: command pin.
- DRAM_UDQM, out, 1: byte mask.
- DRAM_WE_N, out, 1: command pin.

Behaviour:
- Clocking and reset
  - One clock domain, iclk. DRAM_CLK = ~iclk.
  - Synchronous, active-high reset on ireset.
  - All outputs are registered.
- Reset values
  - CS_N=1; RAS_N/CAS_N/WE_N=1; CKE=1.
  - ADDR=0, BA=0, LDQM/UDQM=1.
  - dq_write=0, oread_data=0, both acks 0.
  - State=INIT_WAIT. Reset mid-operation aborts any access and restarts initialisation.
- Commands, as {CS_N,RAS_N,CAS_N,WE_N}:
  - NOP = 0111.
  - PRECHARGE = 0010, with A10=1 (all banks).
  - REFRESH = 0001.
  - LOAD_MODE = 0000.
  - ACTIVE = 0011.
  - READ = 0101.
  - WRITE = 0100.
  - Any cycle that is not issuing a command drives NOP.
  - DQM=0 after initialisation.
- Address mapping
  - BA = addr[21:20].
  - Row = addr[19:7].
  - Column = {3'b0, addr[6:0]}, with A10=1 on READ/WRITE (auto-precharge).
- Mode register: 13'h020 (burst length 1, sequential, CAS latency 2, burst write).
- Initialisation sequence: INIT_WAIT (INIT_WAIT cycles) → PRECHARGE, wait T_RP → REFRESH, wait T_RFC → REFRESH, wait T_RFC → LOAD_MODE, wait 2 cycles → IDLE.
- Refresh
  - The refresh counter starts at IDLE entry and sets refresh_due every REFRESH_PERIOD cycles.
  - REFRESH state issues REFRESH, waits T_RFC, clears refresh_due and returns to IDLE.
- IDLE arbitration, evaluated each cycle: refresh_due > iwrite_req > iread_req.
  - The request's address and data are latched on acceptance.
- Write path
  - ACTIVE, then T_RCD cycles, then WRITE.
  - In the WRITE cycle dq_write = latched data and owrite_ack = 1.
  - Then wait T_WR + T_RP, then IDLE.
- Read path
  - ACTIVE, then T_RCD cycles, then READ.
  - dq_read is captured CAS_LATENCY cycles after READ.
  - oread_data is updated and oread_ack = 1 in the same cycle; then wait T_RP, then IDLE.
  - oread_data holds until the next read completes.
- Request rules
  - Requests are level-sensitive.
  - A request still asserted when the controller returns to IDLE starts a new access, which acks again.
  - A request deasserted before acceptance is dropped.
  - Requests during initialisation, refresh or a busy period wait.
- Input changes after acceptance do not affect the access in progress.

Decomposition:
- Package sdram_pkg:
  - state enum;
  - 4-bit command localparams (NOP, PRECHARGE, REFRESH, LOAD_MODE, ACTIVE, READ, WRITE);
  - MODE_REG constant;
  - address-field slice widths.
- A single module containing the FSM, the wait counter and the refresh counter is natural. No sub-module is required.

Test Plan:
- Reset held for 1 cycle → all outputs at reset values. The init command order on the pins is PRECHARGE, REFRESH, REFRESH, LOAD_MODE with ADDR=13'h020.
- After init, iwrite_req=1, iwrite_address=0, iwrite_data=19 → ACTIVE at BA=0/row 0, WRITE T_RCD cycles later with dq_write=19 and a one-cycle owrite_ack.
- Deassert write; iread_req=1, iread_address=0, against an SDRAM model → READ issued; oread_ack pulses CAS_LATENCY cycles after READ with oread_data=19.
- Write 16'hABCD to address 22'h3FFFFF, then read it back:
  - pins show BA=3, row 13'h1FFF, column 7'h7F;
  - oread_data = 16'hABCD.
- Hold iwrite_req and iread_req together → the write is served first. Refresh asserted at the same time preempts both. A REFRESH appears every REFRESH_PERIOD cycles under continuous request traffic.
- Assert ireset in the middle of a read → no ack; the controller restarts INIT_WAIT, and a later read succeeds.
